// File: rtl/seven_segment_to_binary_if.sv
// Segment-bus interface: display pattern and digit select in, recovered byte and status pulses out.
interface seven_segment_to_binary_if;
    logic [6:0] segments;
    logic       digit_sel;
    logic [7:0] binary_num;
    logic       valid;
    logic       invalid;

    modport master (
        output segments,
        output digit_sel,
        input  binary_num,
        input  valid,
        input  invalid
    );

    modport slave (
        input  segments,
        input  digit_sel,
        output binary_num,
        output valid,
        output invalid
    );
endinterface

// File: rtl/seven_segment_to_binary.sv
// Recovers a two-digit hex byte from a multiplexed 7-segment bus: stability filter,
// table decode, and a pairing FSM that emits once both digits have been captured.
module seven_segment_to_binary #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    seven_segment_to_binary_if.slave   seg_bus
);
    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_PRE  = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]      SEG_XOR  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]      HEX_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic [1:0] {EMPTY, HAVE_ONES, HAVE_TENS, EMIT} state_t;

    logic [7:0]    sample_next;
    logic [7:0]    sample_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;
    logic [15:0]   hit;
    logic [3:0]    nibble;
    logic          code_ok;
    logic          blank;
    logic          sel;

    state_t        state_reg;
    logic [3:0]    ones_reg;
    logic [3:0]    tens_reg;
    logic          inv_pend_reg;
    logic [7:0]    binary_num_reg;
    logic          valid_reg;
    logic          invalid_reg;

    assign sample_next = {seg_bus.digit_sel, seg_bus.segments ^ SEG_XOR};

    // Fires on the one edge where the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES.
    assign accept = (sample_next == sample_reg) && (cnt_reg == CNT_PRE);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (sample_reg[6:0] == HEX_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) nibble = 4'(i);
        end
    end

    assign code_ok = |hit;
    assign blank   = (sample_reg[6:0] == 7'h00);
    assign sel     = sample_reg[7];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sample_reg     <= '0;
            cnt_reg        <= '0;
            state_reg      <= EMPTY;
            ones_reg       <= '0;
            tens_reg       <= '0;
            inv_pend_reg   <= 1'b0;
            binary_num_reg <= 8'h00;
            valid_reg      <= 1'b0;
            invalid_reg    <= 1'b0;
        end else begin
            sample_reg <= sample_next;
            if (sample_next != sample_reg)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + CW'(1);

            valid_reg    <= 1'b0;
            invalid_reg  <= inv_pend_reg;
            inv_pend_reg <= 1'b0;

            if (state_reg == EMIT) begin
                binary_num_reg <= {tens_reg, ones_reg};
                valid_reg      <= 1'b1;
                state_reg      <= EMPTY;
            end else if (accept && !blank) begin
                if (!code_ok) begin
                    // Drop only the digit that was corrupted; the other one stays held.
                    inv_pend_reg <= 1'b1;
                    if (sel && state_reg == HAVE_TENS)
                        state_reg <= EMPTY;
                    else if (!sel && state_reg == HAVE_ONES)
                        state_reg <= EMPTY;
                end else begin
                    if (sel)
                        tens_reg <= nibble;
                    else
                        ones_reg <= nibble;
                    case (state_reg)
                        EMPTY:     state_reg <= sel ? HAVE_TENS : HAVE_ONES;
                        HAVE_ONES: if (sel)  state_reg <= EMIT;
                        HAVE_TENS: if (!sel) state_reg <= EMIT;
                        default:   state_reg <= EMPTY;
                    endcase
                end
            end
        end
    end

    assign seg_bus.binary_num = binary_num_reg;
    assign seg_bus.valid      = valid_reg;
    assign seg_bus.invalid    = invalid_reg;
endmodule
